// File: rtl/uart_tx_scheduler.sv
// Byte FIFO feeding a UART transmitter: the core stores bytes, and a four-state
// scheduler pops one byte per frame, pulses tx_send, then waits for the frame to finish.
module uart_tx_scheduler #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        clr_ovf,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] status,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic [7:0]      r_tx_data;

  logic            w_full;
  logic            w_empty;
  logic            w_busy;
  logic            w_wr_accept;
  logic            w_wr_drop;
  logic            w_pop;

  // Fullness is judged on the registered count, so a pop in the same cycle
  // never makes room for a write to a full FIFO.
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_wr_accept = wr_valid && !w_full;
  assign w_wr_drop   = wr_valid && w_full;
  assign w_busy      = (r_state != IDLE) || !w_empty;

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && tx_ready) begin
          w_pop        = 1'b1;
          w_next_state = SEND;
        end
      end
      SEND:      w_next_state = WAIT_BUSY;
      WAIT_BUSY: if (!tx_ready) w_next_state = WAIT_DONE;
      WAIT_DONE: if (tx_ready)  w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_state <= w_next_state;
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_tx_data <= r_mem[r_rd_ptr];
      end
      if (w_wr_accept && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr_accept && w_pop) r_count <= r_count - CW'(1);
      // An overflowing write in the same cycle as a clear leaves the flag set.
      if (w_wr_drop)    r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  // Storage is never visible while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_accept) r_mem[r_wr_ptr] <= wr_data;
  end

  assign wr_ready  = !w_full;
  assign tx_send   = (r_state == SEND);
  assign tx_data   = r_tx_data;
  assign dbg_state = r_state;
  assign status    = {23'd0, 5'(r_count), r_ovf, w_busy, w_empty, wr_ready};

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios with a scoreboard of expected
// transmitted bytes and a monitor that also models the UART transmitter.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        clr_ovf;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [31:0] status;
  logic [1:0]  dbg_state;

  logic        uart_busy;
  logic        hold_low;
  int          busy_len;
  int          busy_cnt;
  int          send_cnt;
  int          n_checks;
  int          n_pass;
  logic [7:0]  exp_q[$];

  assign tx_ready = !uart_busy && !hold_low;

  uart_tx_scheduler #(.DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .clr_ovf   (clr_ovf),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .status    (status),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: scoreboard compare on every send, plus a UART that stays busy busy_len cycles
  initial begin
    uart_busy = 1'b0;
    busy_cnt  = 0;
    send_cnt  = 0;
    forever begin
      @(negedge clk);
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) uart_busy = 1'b0;
      end
      if (tx_send) begin
        send_cnt++;
        if (exp_q.size() == 0) check("unexpected_send", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else                   check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        uart_busy = 1'b1;
        busy_cnt  = busy_len;
      end
    end
  end

  // Driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    int k = 0;
    while (!wr_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("wr_ready_timeout", 32'd0, 32'd1);
    exp_q.push_back(b);
    wr_valid = 1'b1;
    wr_data  = b;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (!(exp_q.size() == 0 && status == 32'h3) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, k < budget}, 32'd1);
  endtask

  initial begin
    int s0;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    clr_ovf  = 1'b0;
    hold_low = 1'b0;
    busy_len = 10;
    wait_cycles(3);
    reset = 1'b0;
    check("reset_status", status, 32'h0000_0003);
    check("reset_tx_send", {31'd0, tx_send}, 32'd0);
    check("reset_tx_data", {24'd0, tx_data}, 32'd0);

    // Single byte and latency
    exp_q.push_back(8'h41);
    wr_valid = 1'b1;
    wr_data  = 8'h41;
    @(negedge clk);
    wr_valid = 1'b0;
    check("single_status_queued", status, 32'h0000_0015);
    check("single_no_early_send", {31'd0, tx_send}, 32'd0);
    @(negedge clk);
    check("single_send_latency", {31'd0, tx_send}, 32'd1);
    check("single_tx_data", {24'd0, tx_data}, 32'h41);
    check("single_status_busy", status, 32'h0000_0007);
    wait_idle("single_drain", 60);
    check("single_status_done", status, 32'h0000_0003);

    // Burst of 8 on consecutive cycles
    s0 = send_cnt;
    for (int i = 1; i <= 8; i++) begin
      check("burst_wr_ready", {31'd0, wr_ready}, 32'd1);
      exp_q.push_back(8'(i));
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_idle("burst_drain", 400);
    check("burst_send_count", send_cnt - s0, 32'd8);

    // Overflow with the transmitter held busy
    hold_low = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'h10 + 8'(i));
      wr_valid = 1'b1;
      wr_data  = 8'h10 + 8'(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("ovf_status_full", status, 32'h0000_008C);
    check("ovf_wr_ready", {31'd0, wr_ready}, 32'd0);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", status, 32'h0000_0084);
    clr_ovf  = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    @(negedge clk);
    clr_ovf  = 1'b0;
    wr_valid = 1'b0;
    check("ovf_set_wins", status, 32'h0000_008C);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared_again", status, 32'h0000_0084);
    s0 = send_cnt;
    hold_low = 1'b0;
    wait_idle("ovf_drain", 400);
    check("ovf_send_count", send_cnt - s0, 32'd8);

    // Write in the same cycle as the IDLE pop with count=3
    hold_low = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'hA1 + 8'(i));
      wr_valid = 1'b1;
      wr_data  = 8'hA1 + 8'(i);
      @(negedge clk);
    end
    check("simul_count3", status, 32'h0000_0035);
    exp_q.push_back(8'hA4);
    hold_low = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'hA4;
    @(negedge clk);
    wr_valid = 1'b0;
    check("simul_count_stays", status, 32'h0000_0035);
    check("simul_send", {31'd0, tx_send}, 32'd1);
    wait_idle("simul_drain", 200);

    // Wrap: 20 bytes with random gaps and a fast transmitter
    busy_len = 3;
    s0 = send_cnt;
    for (int i = 0; i < 20; i++) begin
      wait_cycles($urandom_range(0, 3));
      write_byte(8'(i * 7 + 3));
    end
    wait_idle("wrap_drain", 400);
    check("wrap_send_count", send_cnt - s0, 32'd20);

    // Reset in WAIT_DONE with 4 queued bytes
    busy_len = 10;
    exp_q.push_back(8'hB0);
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hB0 + 8'(i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    begin
      int k = 0;
      while (dbg_state != 2'd3 && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("rst_reach_wait_done", {31'd0, k < 40}, 32'd1);
    end
    check("rst_pre_status", status, 32'h0000_0045);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_status", status, 32'h0000_0003);
    check("rst_mid_tx_send", {31'd0, tx_send}, 32'd0);
    check("rst_mid_tx_data", {24'd0, tx_data}, 32'd0);
    s0 = send_cnt;
    wait_cycles(30);
    check("rst_no_sends", send_cnt - s0, 32'd0);
    write_byte(8'h5A);
    wait_idle("rst_new_write", 60);
    check("rst_new_send_count", send_cnt - s0, 32'd1);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wr_valid  input  1  byte-write strobe from memory system (UART data register store).
REQ-005 wr_data  input  8  byte to transmit, sampled when wr_valid=1.
REQ-006 wr_ready  output  1  high when the FIFO is not full.
REQ-007 clr_ovf  input  1  one-cycle pulse that clears the sticky overflow flag.
REQ-008 tx_send  output  1  one-cycle send request to the UART transmitter.
REQ-009 tx_data  output  8  byte presented to the transmitter; stable from tx_send until the next pop.
REQ-010 tx_ready  input  1  transmitter idle flag; drops while a frame is shifting out.
REQ-011 status  output  32  register value read back by the core at the UART control address.

Function
REQ-012 The FIFO SHALL be a circular buffer with DEPTH entries, a read pointer, a write pointer and a count of width clog2(DEPTH)+1.
REQ-013 A write SHALL be accepted when wr_valid=1 and count<DEPTH; the byte is stored at the write pointer and count increments at that edge.
REQ-014 A write with count==DEPTH SHALL be dropped, including when a pop occurs in the same cycle; the overflow flag is set and FIFO contents are unchanged.
REQ-015 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated bytes.
REQ-016 In a cycle with both an accepted write and a pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-017 The FSM SHALL have the states IDLE, SEND, WAIT_BUSY and WAIT_DONE.
REQ-018 IDLE: if count>0 and tx_ready=1, the FSM pops the head byte into tx_data and moves to SEND; otherwise it stays in IDLE.
REQ-019 SEND: tx_send=1 for exactly this one cycle; the next state is WAIT_BUSY.
REQ-020 WAIT_BUSY: on tx_ready=0 the next state is WAIT_DONE; otherwise the FSM holds.
REQ-021 WAIT_DONE: on tx_ready=1 the next state is IDLE; otherwise the FSM holds.
REQ-022 tx_send SHALL be 1 only in SEND; there is never more than one tx_send per popped byte.
REQ-023 Latency: a write accepted at edge N into an empty FIFO, with the FSM in IDLE and tx_ready=1, SHALL produce tx_send=1 in the cycle after edge N+1.
REQ-024 Back-to-back bytes SHALL be popped in the IDLE cycle immediately following WAIT_DONE, with no added idle cycle.
REQ-025 The overflow flag SHALL be sticky until clr_ovf=1; if clr_ovf and an overflowing write occur in the same cycle, set wins.
REQ-026 status SHALL be combinational from registers, with these fields:
- bit0 = wr_ready
- bit1 = FIFO empty
- bit2 = busy (state!=IDLE or count>0)
- bit3 = overflow
- bits[8:4] = count, zero-extended
- all other bits 0

Reset
REQ-027 When reset=1 at a rising edge, the block SHALL clear the pointers and count, go to IDLE, clear overflow, and drive tx_send=0 and tx_data=8'h00; reset has priority over writes, pops and clr_ovf.
REQ-028 The status value after reset SHALL be 32'h0000_0003.
REQ-029 Reset asserted mid-frame SHALL abandon the current byte and discard all queued bytes; after release, the FSM waits in IDLE for a new write.
REQ-030 FIFO storage need not be cleared by reset; contents are never visible while count=0.

Verification
REQ-031 Single byte: after reset with tx_ready=1, write 8'h41 -> tx_send pulses once, two cycles later, with tx_data=8'h41; status goes busy and then returns to 32'h0000_0003 after the UART model completes the frame.
REQ-032 Burst: write 8'h01..8'h08 on consecutive cycles (DEPTH=8) with the UART model at 10 busy cycles per byte -> exactly 8 sends in order 01..08, and wr_ready never deasserts because the first pop frees an entry.
REQ-033 Overflow: hold tx_ready=0 and write 9 bytes -> count=8, wr_ready=0, status bit3=1, and the 9th byte is never sent; clr_ovf clears bit3.
REQ-034 Wrap: stream 20 bytes through DEPTH=8 with random write gaps -> the output sequence matches the input with no loss or duplication.
REQ-035 Simultaneous events: write on the same cycle as the IDLE pop with count=3 -> count stays 3; write when full while clr_ovf=1 -> overflow=1.
REQ-036 Reset in WAIT_DONE with 4 queued bytes -> the next cycle shows status=32'h0000_0003 and tx_send=0, and no further sends occur until a new write.
